// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter.
//   - SZ_B/SZ_H/SZ_W/SZ_D : access-size encodings (byte, half, word, double)
//   - state_e             : arbiter FSM states
//   - is_aligned()        : natural-alignment check for a given size
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;

    // Only the three low address bits matter: the largest access is 8 bytes.
    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] addr_lo);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = (addr_lo[0] == 1'b0);
            SZ_W:    ok = (addr_lo[1:0] == 2'b00);
            SZ_D:    ok = (addr_lo == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin arbiter.
//   req[1:0]    in  : request lines (bit N = port N)
//   last_grant  in  : port granted most recently (state is held by the caller)
//   grant[1:0]  out : one-hot grant, 0 when nothing is requested
//   grant_id    out : index of the granted port
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_id
);

    // Single requester always wins; on contention the port not granted last wins.
    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        case (req)
            2'b01: begin
                grant    = 2'b01;
                grant_id = 1'b0;
            end
            2'b10: begin
                grant    = 2'b10;
                grant_id = 1'b1;
            end
            2'b11: begin
                if (last_grant) begin
                    grant    = 2'b01;
                    grant_id = 1'b0;
                end else begin
                    grant    = 2'b10;
                    grant_id = 1'b1;
                end
            end
            default: begin
                grant    = 2'b00;
                grant_id = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises CPU (port 0) and debug/loader (port 1) accesses onto
// a single-port data RAM with round-robin arbitration.
//   pN_req_*   : valid/ready request channel (we, addr, wdata, size)
//   pN_resp_*  : one-cycle response pulse with load data and misalignment error
//   ram_*      : RAM controls; ram_rdata returns one cycle after the address
//   busy       : FSM not in IDLE
//   grant_id   : port owning the current/last transaction
// Aligned access: IDLE -> ACCESS -> RESP. Misaligned access: IDLE -> RESP,
// never reaching the RAM.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req_valid,
    output logic          p0_req_ready,
    input  logic          p0_req_we,
    input  logic [AW-1:0] p0_req_addr,
    input  logic [DW-1:0] p0_req_wdata,
    input  logic [1:0]    p0_req_size,
    output logic          p0_resp_valid,
    output logic [DW-1:0] p0_resp_rdata,
    output logic          p0_resp_err,
    input  logic          p1_req_valid,
    output logic          p1_req_ready,
    input  logic          p1_req_we,
    input  logic [AW-1:0] p1_req_addr,
    input  logic [DW-1:0] p1_req_wdata,
    input  logic [1:0]    p1_req_size,
    output logic          p1_resp_valid,
    output logic [DW-1:0] p1_resp_rdata,
    output logic          p1_resp_err,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic [1:0]    ram_size,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy,
    output logic          grant_id
);

    state_e        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          id_q, id_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [1:0]    size_q, size_d;

    logic [1:0]    grant_s;
    logic          win_id_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;
    logic [1:0]    sel_size_s;
    logic          load_ok_s;

    rr_arb2 u_rr_arb2 (
        .req        ({p1_req_valid, p0_req_valid}),
        .last_grant (last_grant_q),
        .grant      (grant_s),
        .grant_id   (win_id_s)
    );

    // Request fields of the arbitration winner.
    always_comb begin
        if (win_id_s) begin
            sel_we_s    = p1_req_we;
            sel_addr_s  = p1_req_addr;
            sel_wdata_s = p1_req_wdata;
            sel_size_s  = p1_req_size;
        end else begin
            sel_we_s    = p0_req_we;
            sel_addr_s  = p0_req_addr;
            sel_wdata_s = p0_req_wdata;
            sel_size_s  = p0_req_size;
        end
    end

    // Next-state logic; a grant in IDLE is the handshake since grants imply valid.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        we_d         = we_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        case (state_q)
            IDLE: begin
                if (grant_s != 2'b00) begin
                    last_grant_d = win_id_s;
                    id_d         = win_id_s;
                    we_d         = sel_we_s;
                    addr_d       = sel_addr_s;
                    wdata_d      = sel_wdata_s;
                    size_d       = sel_size_s;
                    if (is_aligned(sel_size_s, sel_addr_s[2:0])) begin
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and latched-request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= {AW{1'b0}};
            wdata_q      <= {DW{1'b0}};
            size_q       <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            we_q         <= we_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
        end
    end

    assign p0_req_ready  = (state_q == IDLE) && grant_s[0];
    assign p1_req_ready  = (state_q == IDLE) && grant_s[1];

    // RAM address/data/size simply hold the latched request; only we is gated.
    assign ram_we    = (state_q == ACCESS) && we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_size  = size_q;

    assign busy      = (state_q != IDLE);
    assign grant_id  = id_q;

    assign load_ok_s     = !we_q && !err_q;
    assign p0_resp_valid = (state_q == RESP) && (id_q == 1'b0);
    assign p1_resp_valid = (state_q == RESP) && (id_q == 1'b1);
    assign p0_resp_rdata = (p0_resp_valid && load_ok_s) ? ram_rdata : {DW{1'b0}};
    assign p1_resp_rdata = (p1_resp_valid && load_ok_s) ? ram_rdata : {DW{1'b0}};
    assign p0_resp_err   = p0_resp_valid && err_q;
    assign p1_resp_err   = p1_resp_valid && err_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between two requesters: port 0 is the CPU data port and port 1 is the debug/loader port. Each port uses a valid/ready request channel and a fixed-latency response. The block sits between the core's data-side outputs and the data RAM, and drives the RAM's write enable, address, write data and access-size inputs. It serialises accesses, arbitrates round-robin, and rejects misaligned accesses without touching memory.

## Interface
Parameters:
- AW, 64, address width
- DW, 64, data width

Ports (pN is replicated for N = 0 and 1):
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- pN_req_valid  in  1  request present
- pN_req_ready  out  1  request accepted this cycle when high together with pN_req_valid
- pN_req_we  in  1  1 = store, 0 = load
- pN_req_addr  in  AW  byte address
- pN_req_wdata  in  DW  store data, right-aligned
- pN_req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 double
- pN_resp_valid  out  1  one-cycle response pulse; no backpressure
- pN_resp_rdata  out  DW  load data; 0 for stores and errors
- pN_resp_err  out  1  misaligned access, reported in the same cycle as pN_resp_valid
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_size  out  2  RAM access size, same encoding as pN_req_size
- ram_rdata  in  DW  RAM read data, valid in the cycle after the address is sampled
- busy  out  1  high whenever the state is not IDLE
- grant_id  out  1  port currently owning the transaction

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Select a winner among the valid ports.
  - If both ports are valid, the port that was not last granted wins.
  - The winner's req_ready is high; the other port's req_ready is low.
  - On the handshake, latch we, addr, wdata, size and port id, and update last_grant.
  - Next state: ACCESS if the access is aligned, otherwise RESP with the error flag set.
  - req_ready may depend on the other port's valid. Requesters must not make valid depend on ready.
- Alignment rule:
  - half requires addr[0]=0
  - word requires addr[1:0]=0
  - double requires addr[2:0]=0
  - byte is always aligned
- ACCESS:
  - ram_addr, ram_wdata and ram_size are driven from the latched request.
  - ram_we equals the latched we.
  - Next state: RESP.
- RESP:
  - The granted port gets resp_valid=1 for exactly one cycle.
  - resp_rdata = ram_rdata for a load without error, otherwise 0.
  - resp_err = latched error flag.
  - Next state: IDLE.
- Error path: no cycle with ram_we=1 occurs, and RAM contents are unchanged.
- Outside ACCESS: ram_we=0 and ram_addr, ram_wdata, ram_size hold their last latched values.
- Reset:
  - All outputs are 0; state = IDLE.
  - last_grant = 1, so port 0 wins the first contention.
  - The error flag and latched request are cleared.
- Reset mid-operation: the in-flight transaction is dropped with no response. A reset during ACCESS must yield ram_we=0 from the next cycle on.

## Timing
- A request accepted at edge N has ACCESS in cycle N+1 (RAM samples at the end of N+1). resp_valid is high in cycle N+2.
- Error path: resp_valid is high in cycle N+1.
- Peak throughput is one transaction per 3 cycles (2 cycles for errors). The next acceptance is possible in the cycle after RESP.
- A port holding valid with the other port idle is granted every transaction. Under continuous contention the grants alternate 0,1,0,1.
- A request arriving during ACCESS/RESP waits; ready stays low until IDLE.

## Structure
- Package dmem_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D
  - FSM state enum {IDLE, ACCESS, RESP}
  - the alignment-check function
- Sub-module rr_arb2 is a 2-way round-robin arbiter: inputs req[1:0] and last_grant; outputs grant[1:0] and grant_id. It is purely combinational; last_grant lives in dmem_arbiter.
- The RAM model for the bench uses a 1-cycle read latency and honours the size encoding.

## Test plan
- Reset, then p0 store word 0xDEADBEEF to 0x100 -> ram_we=1 for exactly one cycle (N+1) with ram_addr=0x100 and ram_size=10. p0_resp_valid at N+2 with rdata=0, err=0.
- p0 load word from 0x100 after the store -> p0_resp_rdata=0xDEADBEEF at N+2.
- p0 and p1 valid continuously from reset, both loading distinct addresses -> grant order 0,1,0,1. Acceptances are spaced 3 cycles apart, and each response goes only to its owning port.
- p1 load double at 0x104 -> no ram access, p1_resp_valid at N+1 with err=1 and rdata=0. A following p1 byte load at 0x105 gets err=0.
- rst asserted during ACCESS of a p0 store -> no response, busy=0 and ram_we=0 from the next cycle, and the next contention is won by p0.
